risc32_sseg_scan_bcd: RTL and testbench
=======================================

# risc32_sseg_scan_bcd

Parametrised multiplexed seven-segment driver for the RISC32 board-level I/O. It supports N digits, decimal or hexadecimal display, per-digit decimal points and overflow indication. A binary value is converted to BCD by an iterative double-dabble engine rather than combinational divide/modulo. The converted digits are committed atomically to a display buffer, which a time-multiplexed scanner drives onto shared cathodes and per-digit anodes.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits and anodes (1..8)
- VALUE_WIDTH, 16, width of the binary input (4..32)
- REFRESH_DIV, 65536, clocks each digit stays active (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- value  in  VALUE_WIDTH  binary value to display
- load  in  1  one-cycle strobe that samples value, hex_mode and dp_mask
- hex_mode  in  1  1 = hexadecimal digits, 0 = decimal
- dp_mask  in  NUM_DIGITS  bit i lights the decimal point of digit i (digit 0 = least significant)
- busy  out  1  a conversion is in progress
- overflow  out  1  the committed value does not fit in NUM_DIGITS digits
- sseg_ca  out  8  cathodes, active-low; bit 7 = dp, bits 6:0 = g..a
- sseg_an  out  NUM_DIGITS  anodes, active-low, one-hot-low while scanning

## Operation
- Conversion FSM states:
  - IDLE, CONV, COMMIT.
  - IDLE + load: latch value, mode and dp_mask into working registers. Decimal mode → CONV with bit counter = VALUE_WIDTH. Hex mode → COMMIT directly.
  - CONV: one double-dabble step per cycle (add 3 to every BCD nibble ≥5, then shift left one bit from the working value). After VALUE_WIDTH steps → COMMIT.
  - COMMIT: write the digit buffer, dp buffer and overflow in one cycle → IDLE. If a pending load exists → reload from pending instead of IDLE.
- load while busy: the new inputs are stored in a single pending slot, last writer wins. They start converting immediately after COMMIT. No load is lost except ones overwritten in pending.
- Converter BCD width: CONV_DIGITS = (VALUE_WIDTH*3)/10 + 1 nibbles.
- Decimal overflow: any nibble at or above NUM_DIGITS is nonzero.
- Hex overflow: any value bit at or above 4*NUM_DIGITS is set.
- On overflow, every digit shows SEG_DASH and decimal points are suppressed.
- Digit decode: 0–9 and A–F use the package codes. Values 10–15 in decimal mode cannot occur.
- Scanner:
  - Counter runs 0..REFRESH_DIV-1. On wrap, the digit index advances 0→NUM_DIGITS-1→0.
  - sseg_an drives 0 on the selected digit only.
  - sseg_ca = ~{dp, seg[6:0]} of the selected buffer entry.
  - The scanner runs independently of the FSM; the buffer never changes mid-conversion, so no tearing.

## Timing
- Reset values:
  - FSM = IDLE; busy=0, overflow=0.
  - Buffer blank; scan counter and index = 0; pending empty.
  - sseg_an = all ones; sseg_ca = 8'hFF.
- busy is registered: high from the cycle after the load is accepted until the cycle after COMMIT, when nothing is pending.
- Latency from load sampled at edge t to buffer update:
  - Decimal: t+VALUE_WIDTH+1.
  - Hex: t+1.
- sseg_ca and sseg_an are registered. They reflect the buffer one cycle after a scan step or a buffer update.
- load in the same cycle as COMMIT goes to pending, then converts next.
- rst mid-conversion aborts immediately; no partial buffer write.

## Configuration
- RISC32_SSEG_LZ_BLANK_EN defined:
  - In decimal and hex modes, zero digits above the most significant nonzero digit are blank.
  - Digit 0 is always shown.
  - Decimal points on blanked digits remain governed by dp_mask.
- Undefined: all NUM_DIGITS digits are shown, including leading zeros.

## Structure
- risc32_consts.v gains:
  - SEG_A…SEG_F and SEG_DASH, alongside the existing SEG_0…SEG_9 and SEG_BLANK; 1 = lit, bit order g..a.
  - Default macros for the parameters.
- Sub-module risc32_bin2bcd:
  - Iterative double-dabble engine.
  - Interface: start/value in, done/bcd out, parameterised VALUE_WIDTH.
  - The FSM and scanner stay in the top.

## Test plan
- Decimal, NUM_DIGITS=4, REFRESH_DIV=4, load value=1234 → after 17 cycles busy falls; the scan shows 4,3,2,1 on an=1110,1101,1011,0111; ca for "4" = ~{0,SEG_4}.
- Decimal, value=10000 → overflow=1; all four digits show ~{0,SEG_DASH}.
- Hex, value=16'hBEEF, dp_mask=4'b0100 → buffer updates 1 cycle later; digits F,E,E,B; digit 2 has ca[7]=0.
- With LZ blank: decimal value=7 → digits 3..1 blank (ca=8'hFF), digit 0 shows 7. Without: shows 0007.
- load 42 then load 99 two cycles later → 42 is committed, then 99 converts; the final buffer is 0099/99; busy stays high continuously.
- Assert rst at CONV step 5 → all outputs return to reset values asynchronously; the buffer stays blank until the next load.

Source files
------------

// File: rtl/risc32_sseg_scan_bcd_pkg.sv
// Shared constants, FSM state type and segment decode for the RISC32 seven-segment driver.
// Segment codes: 1 = lit, bit order g..a (bit 0 = a).
`default_nettype none

package risc32_sseg_scan_bcd_pkg;

  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_VALUE_WIDTH = 16;
  localparam int DEF_REFRESH_DIV = 65536;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  // Enough BCD nibbles to hold any VALUE_WIDTH-bit number.
  function automatic int conv_digits(input int vw);
    return (vw * 3) / 10 + 1;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/risc32_sseg_scan_bcd_bin2bcd.sv
// risc32_bin2bcd: iterative double-dabble, one bit per cycle, VALUE_WIDTH cycles per conversion.
// o_done is high during the final step; o_bcd holds the full result from the following cycle.
`default_nettype none

module risc32_bin2bcd
  import risc32_sseg_scan_bcd_pkg::*;
#(
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
  parameter int CONV_DIGITS = conv_digits(VALUE_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [VALUE_WIDTH-1:0]   i_value,
  output logic                     o_done,
  output logic [4*CONV_DIGITS-1:0] o_bcd
);

  localparam int BCD_W = 4 * CONV_DIGITS;
  localparam int CNT_W = $clog2(VALUE_WIDTH + 1);

  logic [VALUE_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]       r_bcd;
  logic [BCD_W-1:0]       w_adj;
  logic [CNT_W-1:0]       r_cnt;

  always_comb begin
    w_adj = r_bcd;
    for (int n = 0; n < CONV_DIGITS; n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_value;
      r_bcd <= '0;
      r_cnt <= CNT_W'(VALUE_WIDTH);
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[BCD_W-2:0], r_bin[VALUE_WIDTH-1]};
      r_bin <= {r_bin[VALUE_WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));
  assign o_bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/risc32_sseg_scan_bcd.sv
// risc32_sseg_scan_bcd: load/convert/commit FSM plus multiplexed digit scanner.
// Define RISC32_SSEG_LZ_BLANK_EN to blank leading zero digits (digit 0 always shown).
`default_nettype none

module risc32_sseg_scan_bcd
  import risc32_sseg_scan_bcd_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   load,
  input  logic                   hex_mode,
  input  logic [NUM_DIGITS-1:0]  dp_mask,
  output logic                   busy,
  output logic                   overflow,
  output logic [7:0]             sseg_ca,
  output logic [NUM_DIGITS-1:0]  sseg_an
);

  localparam int CONV_DIGITS = conv_digits(VALUE_WIDTH);
  localparam int BCD_W       = 4 * CONV_DIGITS;
  localparam int DISP_W      = 4 * NUM_DIGITS;
  localparam int HEX_EXT_W   = (DISP_W > VALUE_WIDTH) ? DISP_W : VALUE_WIDTH;
  localparam int BCD_EXT_W   = (DISP_W > BCD_W) ? DISP_W : BCD_W;
  localparam int SCAN_W      = $clog2(REFRESH_DIV);
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  conv_state_t            r_state;
  logic [VALUE_WIDTH-1:0] r_val;
  logic                   r_hex;
  logic [NUM_DIGITS-1:0]  r_dp;
  logic                   r_pend_v;
  logic [VALUE_WIDTH-1:0] r_pend_val;
  logic                   r_pend_hex;
  logic [NUM_DIGITS-1:0]  r_pend_dp;
  logic                   r_busy;
  logic                   r_ovf;
  logic [6:0]             r_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  r_dpb;

  logic [VALUE_WIDTH-1:0] w_src_val;
  logic                   w_src_hex;
  logic [NUM_DIGITS-1:0]  w_src_dp;
  logic                   w_reload;
  logic                   w_start;
  logic                   w_done;
  logic [BCD_W-1:0]       w_bcd;
  logic [HEX_EXT_W-1:0]   w_hex_ext;
  logic [BCD_EXT_W-1:0]   w_bcd_ext;
  logic [3:0]             w_digit [NUM_DIGITS];
  logic                   w_ovf;
  logic [6:0]             w_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  w_dpo;
`ifdef RISC32_SSEG_LZ_BLANK_EN
  logic [IDX_W-1:0]       w_msd;
`endif

  // A load arriving in the commit cycle is newer than anything pending, so it wins.
  assign w_src_val = load ? value    : r_pend_val;
  assign w_src_hex = load ? hex_mode : r_pend_hex;
  assign w_src_dp  = load ? dp_mask  : r_pend_dp;
  assign w_reload  = load | r_pend_v;
  assign w_start   = ((r_state == ST_IDLE && load) || (r_state == ST_COMMIT && w_reload))
                     && !w_src_hex;

  risc32_bin2bcd #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .CONV_DIGITS (CONV_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_value (w_src_val),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_comb begin
    w_hex_ext = HEX_EXT_W'(r_val);
    w_bcd_ext = BCD_EXT_W'(w_bcd);
    w_ovf     = 1'b0;
    if (r_hex) begin
      for (int b = DISP_W; b < HEX_EXT_W; b++) w_ovf = w_ovf | w_hex_ext[b];
    end else begin
      for (int b = DISP_W; b < BCD_EXT_W; b++) w_ovf = w_ovf | w_bcd_ext[b];
    end
`ifdef RISC32_SSEG_LZ_BLANK_EN
    w_msd = '0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_digit[i] = r_hex ? w_hex_ext[4*i +: 4] : w_bcd_ext[4*i +: 4];
`ifdef RISC32_SSEG_LZ_BLANK_EN
      if (w_digit[i] != 4'd0) w_msd = IDX_W'(i);
`endif
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef RISC32_SSEG_LZ_BLANK_EN
      w_seg[i] = w_ovf ? SEG_DASH
               : ((IDX_W'(i) <= w_msd) ? seg_decode(w_digit[i]) : SEG_BLANK);
`else
      w_seg[i] = w_ovf ? SEG_DASH : seg_decode(w_digit[i]);
`endif
      w_dpo[i] = !w_ovf && r_dp[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_val      <= '0;
      r_hex      <= 1'b0;
      r_dp       <= '0;
      r_pend_v   <= 1'b0;
      r_pend_val <= '0;
      r_pend_hex <= 1'b0;
      r_pend_dp  <= '0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_dpb      <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) r_seg[i] <= SEG_BLANK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_val   <= value;
            r_hex   <= hex_mode;
            r_dp    <= dp_mask;
            r_busy  <= 1'b1;
            r_state <= hex_mode ? ST_COMMIT : ST_CONV;
          end
        end
        ST_CONV: begin
          if (load) begin
            r_pend_v   <= 1'b1;
            r_pend_val <= value;
            r_pend_hex <= hex_mode;
            r_pend_dp  <= dp_mask;
          end
          if (w_done) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          for (int i = 0; i < NUM_DIGITS; i++) r_seg[i] <= w_seg[i];
          r_dpb <= w_dpo;
          r_ovf <= w_ovf;
          if (w_reload) begin
            r_val    <= w_src_val;
            r_hex    <= w_src_hex;
            r_dp     <= w_src_dp;
            r_pend_v <= 1'b0;
            r_state  <= w_src_hex ? ST_COMMIT : ST_CONV;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic [SCAN_W-1:0] r_scan_cnt;
  logic [IDX_W-1:0]  r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      sseg_an    <= '1;
      sseg_ca    <= 8'hFF;
    end else begin
      if (r_scan_cnt == SCAN_W'(REFRESH_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_idx      <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      sseg_an <= ~(NUM_DIGITS'(1) << r_idx);
      sseg_ca <= ~{r_dpb[r_idx], r_seg[r_idx]};
    end
  end

  assign busy     = r_busy;
  assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_risc32_sseg_scan_bcd.sv
// Self-checking bench for risc32_sseg_scan_bcd: directed scenarios plus randomized loads
// checked against a digit-arithmetic reference model.
`default_nettype none

module tb_risc32_sseg_scan_bcd;

  localparam int ND = 4;
  localparam int VW = 16;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [VW-1:0] value = '0;
  logic          load = 1'b0;
  logic          hex_mode = 1'b0;
  logic [ND-1:0] dp_mask = '0;
  logic          busy;
  logic          overflow;
  logic [7:0]    sseg_ca;
  logic [ND-1:0] sseg_an;

  int vectors = 0;
  int errors  = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  risc32_sseg_scan_bcd #(
    .NUM_DIGITS  (ND),
    .VALUE_WIDTH (VW),
    .REFRESH_DIV (RD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .hex_mode (hex_mode),
    .dp_mask  (dp_mask),
    .busy     (busy),
    .overflow (overflow),
    .sseg_ca  (sseg_ca),
    .sseg_an  (sseg_an)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  function automatic logic model_ovf(input logic [VW-1:0] v, input logic hx);
    longint unsigned lim = 1;
    for (int k = 0; k < ND; k++) lim = lim * (hx ? 16 : 10);
    return longint'(v) >= lim;
  endfunction

  function automatic logic [7:0] model_ca(input logic [VW-1:0] v, input logic hx,
                                          input logic [ND-1:0] dp, input int i);
    longint unsigned base = hx ? 16 : 10;
    longint unsigned tmp  = v;
    int   dig [ND];
    int   msd = 0;
    logic ovf = model_ovf(v, hx);
    logic shown = 1'b1;
    logic [6:0] s;
    for (int k = 0; k < ND; k++) begin
      dig[k] = int'(tmp % base);
      tmp    = tmp / base;
      if (dig[k] != 0) msd = k;
    end
`ifdef RISC32_SSEG_LZ_BLANK_EN
    shown = (i <= msd);
`endif
    s = ovf ? 7'h40 : (shown ? seg_tab[dig[i]] : 7'h00);
    return ~{(ovf ? 1'b0 : dp[i]), s};
  endfunction

  // Pulse load for exactly one edge; returns at #1 after that edge.
  task automatic apply_load(input logic [VW-1:0] v, input logic hx, input logic [ND-1:0] dp);
    @(posedge clk); #1;
    value = v; hex_mode = hx; dp_mask = dp; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Loads, checks busy/latency/overflow, then watches one full scan round.
  task automatic test_conversion(input string name, input logic [VW-1:0] v, input logic hx,
                                 input logic [ND-1:0] dp);
    int n = 0;
    int exp_lat = hx ? 1 : VW + 1;
    logic [ND-1:0] seen = '0;
    int idx;
    logic [7:0] exp_ca;
    apply_load(v, hx, dp);
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_load: got %b expected 1", name, busy);
    end
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d cycles expected %0d", name, n, exp_lat);
    end
    vectors++;
    if (overflow !== model_ovf(v, hx)) begin
      errors++; $display("FAIL %s overflow: got %b expected %b", name, overflow, model_ovf(v, hx));
    end
    @(posedge clk); #1;
    for (int c = 0; c < ND * RD + 2; c++) begin
      idx = -1;
      for (int k = 0; k < ND; k++) if (sseg_an === ~(ND'(1) << k)) idx = k;
      vectors++;
      if (idx < 0) begin
        errors++; $display("FAIL %s anode_onehot: got %b expected one-hot-low", name, sseg_an);
      end else begin
        exp_ca = model_ca(v, hx, dp, idx);
        seen[idx] = 1'b1;
        if (sseg_ca !== exp_ca) begin
          errors++;
          $display("FAIL %s cathode digit%0d: got %h expected %h", name, idx, sseg_ca, exp_ca);
        end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (seen !== '1) begin
      errors++; $display("FAIL %s scan_coverage: got %b expected all digits", name, seen);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    vectors++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_status: got busy=%b ovf=%b expected 0 0", busy, overflow);
    end
    vectors++;
    if (sseg_an !== '1 || sseg_ca !== 8'hFF) begin
      errors++; $display("FAIL reset_outputs: got an=%b ca=%h expected 1111 ff", sseg_an, sseg_ca);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < ND * RD; c++) begin
      vectors++;
      if (sseg_ca !== 8'hFF) begin
        errors++; $display("FAIL reset_blank: got ca=%h expected ff", sseg_ca);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_decimal();
    test_conversion("dec_1234", 16'd1234, 1'b0, 4'b0000);
    test_conversion("dec_dp", 16'd9021, 1'b0, 4'b1010);
  endtask

  task automatic test_overflow();
    test_conversion("dec_10000", 16'd10000, 1'b0, 4'b1111);
    test_conversion("dec_9999", 16'd9999, 1'b0, 4'b0001);
    test_conversion("dec_65535", 16'hFFFF, 1'b0, 4'b0000);
  endtask

  task automatic test_reset_mid();
    // Leave an overflowed value committed so the reset visibly clears it.
    test_conversion("pre_reset", 16'd12345, 1'b0, 4'b0000);
    apply_load(16'd4321, 1'b0, 4'b0011);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || overflow !== 1'b0 || sseg_an !== '1 || sseg_ca !== 8'hFF) begin
      errors++;
      $display("FAIL reset_mid_async: got busy=%b ovf=%b an=%b ca=%h expected 0 0 1111 ff",
               busy, overflow, sseg_an, sseg_ca);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (VW + 4) begin
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || sseg_ca !== 8'hFF) begin
        errors++; $display("FAIL reset_mid_blank: got busy=%b ca=%h expected 0 ff", busy, sseg_ca);
      end
    end
  endtask

  task automatic test_hex();
    test_conversion("hex_beef", 16'hBEEF, 1'b1, 4'b0100);
    test_conversion("hex_00a0", 16'h00A0, 1'b1, 4'b1000);
  endtask

  task automatic test_leading_zero();
    test_conversion("dec_7", 16'd7, 1'b0, 4'b0000);
    test_conversion("dec_0", 16'd0, 1'b0, 4'b0100);
    test_conversion("hex_3", 16'h0003, 1'b1, 4'b0000);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int lows = 0;
    apply_load(16'd42, 1'b0, 4'b0000);
    @(posedge clk); #1;
    value = 16'd99; hex_mode = 1'b0; dp_mask = 4'b0000; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    // 42 commits VW+1 edges after its load, 99 a further VW+1 edges later.
    while (n < 200) begin
      if (busy !== 1'b1) break;
      @(posedge clk); #1; n++;
      if (busy !== 1'b1 && n < 2 * (VW + 1) - 2) lows++;
    end
    vectors++;
    if (lows != 0) begin
      errors++; $display("FAIL b2b_busy_continuous: got %0d low cycles expected 0", lows);
    end
    vectors++;
    if (n != 2 * (VW + 1) - 2) begin
      errors++; $display("FAIL b2b_latency: got %0d cycles expected %0d", n, 2 * (VW + 1) - 2);
    end
    @(posedge clk); #1;
    for (int c = 0; c < ND * RD; c++) begin
      for (int k = 0; k < ND; k++) begin
        if (sseg_an === ~(ND'(1) << k)) begin
          vectors++;
          if (sseg_ca !== model_ca(16'd99, 1'b0, 4'b0000, k)) begin
            errors++;
            $display("FAIL b2b_final digit%0d: got %h expected %h", k, sseg_ca,
                     model_ca(16'd99, 1'b0, 4'b0000, k));
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] v;
    logic hx;
    logic [ND-1:0] dp;
    for (int r = 0; r < 16; r++) begin
      case ($urandom_range(0, 2))
        0:       v = VW'($urandom_range(0, 99));
        1:       v = VW'($urandom_range(0, 9999));
        default: v = VW'($urandom_range(0, 65535));
      endcase
      hx = 1'($urandom_range(0, 1));
      dp = ND'($urandom_range(0, 15));
      test_conversion("random", v, hx, dp);
    end
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_overflow();
    test_reset_mid();
    test_hex();
    test_leading_zero();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
